// File: rtl/tempo_button_controller_pkg.sv
// Shared definitions for the tempo button controller: FSM state encoding,
// default tempo limits and the tempo width.
package tempo_pkg;

    localparam int BPM_W       = 8;
    localparam int BPM_MIN     = 40;
    localparam int BPM_MAX     = 240;
    localparam int BPM_DEFAULT = 120;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HOLD_UP   = 3'd1,
        ST_HOLD_DN   = 3'd2,
        ST_REPEAT_UP = 3'd3,
        ST_REPEAT_DN = 3'd4,
        ST_CHORD     = 3'd5
    } state_t;

    // Drives the holding output: true while a single button is being held.
    function automatic logic is_hold_state(input state_t s);
        logic r;
        case (s)
            ST_HOLD_UP, ST_HOLD_DN, ST_REPEAT_UP, ST_REPEAT_DN: r = 1'b1;
            default:                                            r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tempo_button_controller_if.sv
// Bundle of debounced button events (from the debouncers) and the tempo
// outputs (to the beat generator).
interface tempo_button_controller_if #(
    parameter int BPM_W = tempo_pkg::BPM_W
);
    logic             up_pressed;
    logic             up_released;
    logic             up_state;
    logic             down_pressed;
    logic             down_released;
    logic             down_state;
    logic [BPM_W-1:0] bpm;
    logic             bpm_changed;
    logic             holding;

    modport master (
        output up_pressed, up_released, up_state,
        output down_pressed, down_released, down_state,
        input  bpm, bpm_changed, holding
    );

    modport slave (
        input  up_pressed, up_released, up_state,
        input  down_pressed, down_released, down_state,
        output bpm, bpm_changed, holding
    );
endinterface

// File: rtl/tempo_button_controller_ms_tick_gen.sv
// Millisecond tick prescaler: tick is high for one cycle every TICK_DIV
// cycles; clear restarts the count so a new state always sees a full period.
module ms_tick_gen #(
    parameter int TICK_DIV = 27000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int            CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST     = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(TICK_DIV - 2);
    localparam logic          SINGLE   = (TICK_DIV == 1);

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Prescaler; tick_r is precomputed one count early so it is high exactly
    // while cnt_r sits at its wrap value.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r  <= {CW{1'b0}};
            tick_r <= 1'b0;
        end else if (clear) begin
            cnt_r  <= {CW{1'b0}};
            tick_r <= SINGLE;
        end else begin
            cnt_r  <= (cnt_r == LAST) ? {CW{1'b0}} : cnt_r + {{(CW-1){1'b0}}, 1'b1};
            tick_r <= SINGLE | (cnt_r == PRE_LAST);
        end
    end

    assign tick = tick_r;
endmodule

// File: rtl/tempo_button_controller.sv
// Turns debounced up/down button events into a BPM value with single step,
// auto-repeat and chord-to-default. `define TEMPO_WRAP_EN to wrap at the limits.
module tempo_button_controller #(
    parameter int TICK_DIV      = 27000,
    parameter int LONG_PRESS_MS = 500,
    parameter int REPEAT_MS     = 100,
    parameter int BPM_W         = tempo_pkg::BPM_W,
    parameter int BPM_MIN       = tempo_pkg::BPM_MIN,
    parameter int BPM_MAX       = tempo_pkg::BPM_MAX,
    parameter int BPM_DEFAULT   = tempo_pkg::BPM_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    tempo_button_controller_if.slave  bus
);
    import tempo_pkg::*;

`ifdef TEMPO_WRAP_EN
    localparam logic WRAP_EN = 1'b1;
`else
    localparam logic WRAP_EN = 1'b0;
`endif

    localparam int MS_MAX = (LONG_PRESS_MS > REPEAT_MS) ? LONG_PRESS_MS : REPEAT_MS;
    localparam int MS_W   = $clog2(MS_MAX + 1);

    localparam logic [BPM_W-1:0] BPM_MIN_V  = BPM_W'(BPM_MIN);
    localparam logic [BPM_W-1:0] BPM_MAX_V  = BPM_W'(BPM_MAX);
    localparam logic [BPM_W-1:0] BPM_DEF_V  = BPM_W'(BPM_DEFAULT);
    localparam logic [MS_W-1:0]  LONG_LAST  = MS_W'(LONG_PRESS_MS - 1);
    localparam logic [MS_W-1:0]  REP_LAST   = MS_W'(REPEAT_MS - 1);
    localparam logic [MS_W-1:0]  MS_ONE     = MS_W'(1);

    // Limits are checked before the add/sub, so the arithmetic never overflows.
    function automatic logic [BPM_W-1:0] stepped(input logic [BPM_W-1:0] cur,
                                                 input logic up);
        logic [BPM_W-1:0] r;
        if (up) begin
            if (cur >= BPM_MAX_V) r = WRAP_EN ? BPM_MIN_V : cur;
            else                  r = cur + {{(BPM_W-1){1'b0}}, 1'b1};
        end else begin
            if (cur <= BPM_MIN_V) r = WRAP_EN ? BPM_MAX_V : cur;
            else                  r = cur - {{(BPM_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    state_t           state_r;
    state_t           next_s;
    logic [BPM_W-1:0] bpm_r;
    logic [BPM_W-1:0] bpm_next_s;
    logic             bpm_changed_r;
    logic             holding_r;
    logic [MS_W-1:0]  ms_r;
    logic [MS_W-1:0]  ms_next_s;
    logic             clear_s;
    logic             tick_s;
    logic             own_up_s;
    logic             opp_pressed_s;
    logic             own_gone_s;
    logic [MS_W-1:0]  thresh_s;

    ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (clear_s),
        .tick  (tick_s)
    );

    // Next-state, next-tempo and ms counter decisions; the four hold/repeat
    // states share one branch, selected by the button they track.
    always_comb begin
        next_s        = state_r;
        bpm_next_s    = bpm_r;
        ms_next_s     = ms_r;
        own_up_s      = (state_r == ST_HOLD_UP) || (state_r == ST_REPEAT_UP);
        opp_pressed_s = own_up_s ? bus.down_pressed : bus.up_pressed;
        own_gone_s    = own_up_s ? (bus.up_released || !bus.up_state)
                                 : (bus.down_released || !bus.down_state);
        thresh_s      = ((state_r == ST_REPEAT_UP) || (state_r == ST_REPEAT_DN))
                        ? REP_LAST : LONG_LAST;
        case (state_r)
            ST_IDLE: begin
                if ((bus.up_pressed && (bus.down_pressed || bus.down_state)) ||
                    (bus.down_pressed && bus.up_state)) begin
                    bpm_next_s = BPM_DEF_V;
                    next_s     = ST_CHORD;
                end else if (bus.up_pressed) begin
                    bpm_next_s = stepped(bpm_r, 1'b1);
                    next_s     = ST_HOLD_UP;
                end else if (bus.down_pressed) begin
                    bpm_next_s = stepped(bpm_r, 1'b0);
                    next_s     = ST_HOLD_DN;
                end else begin
                    next_s     = ST_IDLE;
                end
            end
            ST_HOLD_UP, ST_HOLD_DN, ST_REPEAT_UP, ST_REPEAT_DN: begin
                if (opp_pressed_s) begin
                    bpm_next_s = BPM_DEF_V;
                    next_s     = ST_CHORD;
                end else if (own_gone_s) begin
                    next_s     = ST_IDLE;
                end else if (tick_s && (ms_r == thresh_s)) begin
                    // Staying in REPEAT does not clear, so restart the interval here.
                    bpm_next_s = stepped(bpm_r, own_up_s);
                    next_s     = own_up_s ? ST_REPEAT_UP : ST_REPEAT_DN;
                    ms_next_s  = {MS_W{1'b0}};
                end else if (tick_s) begin
                    ms_next_s  = ms_r + MS_ONE;
                end else begin
                    ms_next_s  = ms_r;
                end
            end
            ST_CHORD: begin
                if (!bus.up_state && !bus.down_state) next_s = ST_IDLE;
                else                                  next_s = ST_CHORD;
            end
            default: next_s = ST_IDLE;
        endcase
        clear_s = (next_s != state_r);
    end

    // State, tempo register and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            bpm_r         <= BPM_DEF_V;
            bpm_changed_r <= 1'b0;
            holding_r     <= 1'b0;
            ms_r          <= {MS_W{1'b0}};
        end else begin
            state_r       <= next_s;
            bpm_r         <= bpm_next_s;
            bpm_changed_r <= (bpm_next_s != bpm_r);
            holding_r     <= is_hold_state(next_s);
            ms_r          <= clear_s ? {MS_W{1'b0}} : ms_next_s;
        end
    end

    assign bus.bpm         = bpm_r;
    assign bus.bpm_changed = bpm_changed_r;
    assign bus.holding     = holding_r;
endmodule

// File: tb/tb_tempo_button_controller.sv
// Randomised and directed bench for tempo_button_controller, checked against
// a cycle-count reference model through an expected-response queue.
module tb_tempo_button_controller;
    localparam int TD = 10, LP = 5, RP = 2;
    localparam int BMIN = 40, BMAX = 240, BDEF = 120;
    localparam int L = LP * TD;
    localparam int R = RP * TD;
`ifdef TEMPO_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tempo_button_controller_if #(.BPM_W(8)) bus();

    tempo_button_controller #(
        .TICK_DIV(TD), .LONG_PRESS_MS(LP), .REPEAT_MS(RP), .BPM_W(8),
        .BPM_MIN(BMIN), .BPM_MAX(BMAX), .BPM_DEFAULT(BDEF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] bpm;
        logic       chg;
        logic       hold;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: mode 0 idle, 1 holding up, 2 holding down, 3 chord.
    int   m_bpm  = BDEF;
    int   m_mode = 0;
    int   m_el   = 0;
    bit   up_prev = 1'b0, dn_prev = 1'b0;

    function automatic int stepped(input int cur, input bit up);
        if (up) return (cur >= BMAX) ? (WRAP ? BMIN : cur) : cur + 1;
        else    return (cur <= BMIN) ? (WRAP ? BMAX : cur) : cur - 1;
    endfunction

    task automatic model_edge(input bit r, input bit upp, input bit upr, input bit ups,
                              input bit dnp, input bit dnr, input bit dns);
        int   nb;
        bit   opp, gone, chg;
        exp_t e;
        nb = m_bpm;
        opp  = (m_mode == 1) ? dnp : upp;
        gone = (m_mode == 1) ? (upr || !ups) : (dnr || !dns);
        if (r) begin
            nb = BDEF;
            m_mode = 0;
        end else begin
            case (m_mode)
                0: begin
                    if ((upp && (dnp || dns)) || (dnp && ups)) begin
                        nb = BDEF; m_mode = 3;
                    end else if (upp) begin
                        nb = stepped(m_bpm, 1'b1); m_mode = 1; m_el = 0;
                    end else if (dnp) begin
                        nb = stepped(m_bpm, 1'b0); m_mode = 2; m_el = 0;
                    end
                end
                1, 2: begin
                    if (opp) begin
                        nb = BDEF; m_mode = 3;
                    end else if (gone) begin
                        m_mode = 0;
                    end else begin
                        m_el++;
                        if (m_el >= L && ((m_el - L) % R) == 0) nb = stepped(m_bpm, m_mode == 1);
                    end
                end
                default: if (!ups && !dns) m_mode = 0;
            endcase
        end
        chg = !r && (nb != m_bpm);
        m_bpm = nb;
        e.bpm  = 8'(m_bpm);
        e.chg  = chg;
        e.hold = (m_mode == 1) || (m_mode == 2);
        exp_q.push_back(e);
    endtask

    // One cycle of stimulus: button levels, with debouncer-style edge pulses.
    task automatic drive(input bit r, input bit u, input bit d);
        bit upp, upr, dnp, dnr;
        @(negedge clk);
        upp = u & ~up_prev;  upr = ~u & up_prev;
        dnp = d & ~dn_prev;  dnr = ~d & dn_prev;
        reset = r;
        bus.up_pressed = upp;   bus.up_released = upr;   bus.up_state = u;
        bus.down_pressed = dnp; bus.down_released = dnr; bus.down_state = d;
        model_edge(r, upp, upr, u, dnp, dnr, d);
        up_prev = u;
        dn_prev = d;
    endtask

    task automatic peek(input string name, input int b, input bit c, input bit h);
        @(posedge clk);
        #1;
        checks++;
        if (bus.bpm !== 8'(b) || bus.bpm_changed !== c || bus.holding !== h) begin
            errors++;
            $display("FAIL %s: got bpm=%0d chg=%0b hold=%0b, want bpm=%0d chg=%0b hold=%0b",
                     name, bus.bpm, bus.bpm_changed, bus.holding, b, c, h);
        end
    endtask

    // Scoreboard monitor: one expected entry per clock edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.bpm !== e.bpm || bus.bpm_changed !== e.chg || bus.holding !== e.hold) begin
                errors++;
                $display("FAIL scoreboard t=%0t: got bpm=%0d chg=%0b hold=%0b, want bpm=%0d chg=%0b hold=%0b",
                         $time, bus.bpm, bus.bpm_changed, bus.holding, e.bpm, e.chg, e.hold);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int up_left, dn_left;
        bit up_lvl, dn_lvl, rr;
        bus.up_pressed = 1'b0;   bus.up_released = 1'b0;   bus.up_state = 1'b0;
        bus.down_pressed = 1'b0; bus.down_released = 1'b0; bus.down_state = 1'b0;

        repeat (2) drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        peek("reset", BDEF, 1'b0, 1'b0);

        // Short press
        drive(1'b0, 1'b1, 1'b0);
        peek("short_press", 121, 1'b1, 1'b1);
        repeat (19) drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        peek("short_release", 121, 1'b0, 1'b0);
        repeat (10) drive(1'b0, 1'b0, 1'b0);
        peek("short_idle", 121, 1'b0, 1'b0);

        // Long press down
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 120; i++) begin
            drive(1'b0, 1'b0, 1'b1);
            case (i)
                0:       peek("long_p1", 119, 1'b1, 1'b1);
                49:      peek("long_p50", 119, 1'b0, 1'b1);
                50:      peek("long_p51", 118, 1'b1, 1'b1);
                70:      peek("long_p71", 117, 1'b1, 1'b1);
                90:      peek("long_p91", 116, 1'b1, 1'b1);
                110:     peek("long_p111", 115, 1'b1, 1'b1);
                default: ;
            endcase
        end
        drive(1'b0, 1'b0, 1'b0);
        peek("long_release", 115, 1'b0, 1'b0);

        // Chord from REPEAT_UP
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 76; i++) drive(1'b0, 1'b1, 1'b0);
        peek("chord_pre", 123, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        peek("chord_entry", BDEF, 1'b1, 1'b0);
        repeat (60) drive(1'b0, 1'b1, 1'b1);
        peek("chord_both", BDEF, 1'b0, 1'b0);
        repeat (30) drive(1'b0, 1'b0, 1'b1);
        peek("chord_one", BDEF, 1'b0, 1'b0);
        repeat (2) drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        peek("chord_after", 121, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);

        // Upper limit via auto-repeat
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2450; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            if (i == 2410) peek("max_reach", BMAX, 1'b1, 1'b1);
            if (i == 2430) peek("max_hold", WRAP ? BMIN : BMAX, WRAP, 1'b1);
        end
        drive(1'b0, 1'b0, 1'b0);
        if (!WRAP) begin
            drive(1'b0, 1'b1, 1'b0);
            peek("max_press", BMAX, 1'b0, 1'b1);
            drive(1'b0, 1'b0, 1'b0);
        end

        // Lower limit via auto-repeat
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 1700; i++) begin
            drive(1'b0, 1'b0, 1'b1);
            if (i == 1610) peek("min_reach", BMIN, 1'b1, 1'b1);
            if (i == 1630) peek("min_hold", WRAP ? BMAX : BMIN, WRAP, 1'b1);
        end
        drive(1'b0, 1'b0, 1'b0);

        // Reset in REPEAT_DN with the button still held
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 80; i++) drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        peek("mid_reset", BDEF, 1'b0, 1'b0);
        repeat (100) drive(1'b0, 1'b0, 1'b1);
        peek("held_after_reset", BDEF, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        peek("new_press", 119, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);

        // Random button activity
        up_lvl = 1'b0; dn_lvl = 1'b0;
        up_left = $urandom_range(1, 30);
        dn_left = $urandom_range(1, 30);
        for (int i = 0; i < 4000; i++) begin
            if (--up_left == 0) begin
                up_lvl = ~up_lvl;
                up_left = up_lvl ? $urandom_range(1, 140) : $urandom_range(1, 40);
            end
            if (--dn_left == 0) begin
                dn_lvl = ~dn_lvl;
                dn_left = dn_lvl ? $urandom_range(1, 140) : $urandom_range(1, 40);
            end
            rr = ($urandom_range(0, 599) == 0);
            drive(rr, up_lvl, dn_lvl);
        end

        repeat (3) drive(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d entries left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tempo_button_controller.md
Name: tempo_button_controller

Overview:
Converts debounced up/down button events into a metronome tempo value (BPM).
- Single press steps BPM by 1.
- Long press auto-repeats.
- Chord (both buttons) restores the default tempo.
- Sits between two button_debouncer instances and the beat generator; it is the only writer of the tempo register.

Parameters:
- TICK_DIV, 27000, clk cycles per 1 ms tick (27 MHz board clock).
- LONG_PRESS_MS, 500, hold time before auto-repeat starts.
- REPEAT_MS, 100, auto-repeat interval.
- BPM_W, 8, width of bpm.
- BPM_MIN, 40, lowest tempo.
- BPM_MAX, 240, highest tempo.
- BPM_DEFAULT, 120, reset/chord tempo; BPM_MIN <= BPM_DEFAULT <= BPM_MAX.

Ports:
- clk  in  1  system clock; sole clock.
- reset  in  1  synchronous, active-high reset.
- up_pressed  in  1  1-cycle pulse from up debouncer.
- up_released  in  1  1-cycle pulse from up debouncer.
- up_state  in  1  debounced level, 1 = held.
- down_pressed  in  1  1-cycle pulse from down debouncer.
- down_released  in  1  1-cycle pulse from down debouncer.
- down_state  in  1  debounced level, 1 = held.
- bpm  out  BPM_W  current tempo, registered.
- bpm_changed  out  1  1-cycle pulse, same cycle bpm takes a new value.
- holding  out  1  high in HOLD or REPEAT states.

Behaviour:
- One clock domain (clk); reset is synchronous and active-high.
- Reset values:
  - bpm = BPM_DEFAULT; bpm_changed = 0; holding = 0.
  - State = IDLE; prescaler = 0; ms counter = 0.
- ms tick:
  - Prescaler counts 0..TICK_DIV-1 and pulses tick at wrap.
  - Prescaler and ms counter are synchronously cleared on every state entry.
- Latency: all bpm updates are registered and appear 1 cycle after the causing input or tick.
- States: IDLE, HOLD_UP, HOLD_DN, REPEAT_UP, REPEAT_DN, CHORD.
- IDLE:
  - up_pressed with down_state=0 and down_pressed=0 -> step +1, go to HOLD_UP.
  - Mirror case for down -> step -1, go to HOLD_DN.
  - Both pressed in the same cycle, or one pressed while the other's state=1 -> bpm = BPM_DEFAULT, go to CHORD.
- HOLD_x:
  - ms counter increments per tick.
  - Reaching LONG_PRESS_MS -> step, go to REPEAT_x.
- REPEAT_x: every REPEAT_MS ticks -> step.
- HOLD/REPEAT exit, with priority in this order:
  1. Opposite button pressed -> CHORD, with chord action.
  2. Own released, or own state=0 -> IDLE, no step, even if a tick or threshold coincides.
  3. Threshold reached -> step.
- CHORD:
  - No stepping.
  - Stay until up_state=0 and down_state=0, then go to IDLE.
  - bpm_changed pulses on chord entry only if bpm differed from BPM_DEFAULT.
- Step boundaries:
  - +1 at BPM_MAX, or -1 at BPM_MIN -> bpm unchanged, no bpm_changed pulse.
  - State timing continues unchanged.
- Releases arriving in IDLE are ignored.
- A level still held after reset does not step; only a new pressed pulse acts.
- Reset mid-operation overrides all inputs in that cycle.
- Arithmetic: unsigned BPM_W bits; comparisons against BPM_MIN/BPM_MAX are done before add/sub, so no overflow is possible.

Optional Feature:
- Macro: TEMPO_WRAP_EN.
- Defined:
  - +1 at BPM_MAX -> bpm = BPM_MIN, bpm_changed pulses.
  - -1 at BPM_MIN -> bpm = BPM_MAX, bpm_changed pulses.
  - Auto-repeat wraps continuously.
- Undefined: saturating behaviour as described above.

Decomposition:
- Shared package tempo_pkg holds:
  - state encoding (3-bit localparams for the 6 states);
  - default BPM_MIN, BPM_MAX, BPM_DEFAULT;
  - BPM_W.
- One sub-module, ms_tick_gen:
  - parameter TICK_DIV;
  - inputs clk, reset, clear;
  - output tick.
- State machine, ms counter and bpm register stay in the top module.

Test Plan:
Sim parameters: TICK_DIV=10, LONG_PRESS_MS=5, REPEAT_MS=2, defaults otherwise.
- Reset: assert reset 3 cycles -> bpm=120, bpm_changed=0, holding=0.
- Short press: up_pressed pulse, up_released 20 cycles later -> bpm=121 one cycle after the press, exactly one bpm_changed pulse, back to IDLE, no further change.
- Long press down: down_pressed, then hold state=1 for 120 cycles -> bpm 119 at press+1, 118 at press+51, 117 at press+71, 116 at press+91, 115 at press+111; release -> IDLE.
- Saturation with BPM_DEFAULT=239, two up presses -> bpm 240 with one pulse, second press gives no change and no pulse. With TEMPO_WRAP_EN -> second press gives bpm=40 with a pulse.
- Chord: hold up into REPEAT_UP (bpm=123), then down_pressed -> bpm=120 with a pulse; no steps while either button is held; IDLE after both release.
- Reset mid-REPEAT_DN with down_state held -> bpm=120, IDLE, no step until a new down_pressed pulse.
